// File: rtl/weight_fetch_ctrl.sv
// Weight-memory fetch controller: issues row reads and buffers the returned
// rows in a 2-entry FIFO that feeds the FC PE array through a valid/ready handshake.
module weight_fetch_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int parallel_fc_PE = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH-1:0]                num_reads,
  output logic [ADDR_WIDTH-1:0]                address_fc,
  output logic                                 read_en_MM_fc,
  output logic                                 enable_MM_out_fc,
  input  logic [DATA_WIDTH*parallel_fc_PE-1:0] dataMainMemo_fc,
  output logic [DATA_WIDTH*parallel_fc_PE-1:0] weights_out,
  output logic                                 weights_valid,
  input  logic                                 weights_ready,
  output logic [ADDR_WIDTH-1:0]                row_idx,
  output logic                                 busy,
  output logic                                 done
);

  localparam int RW = DATA_WIDTH * parallel_fc_PE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] num_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic                  busy_q;
  logic                  done_q;

  logic [RW-1:0]         data_q [2];
  logic [ADDR_WIDTH-1:0] idx_q  [2];
  logic                  wr_q;
  logic                  rd_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;

  logic                  issue;
  logic                  pending;
  logic                  last_issue;
  logic                  push;
  logic                  pop;
  logic                  valid;

  // The memory samples address on the falling edge, so a read issued
  // in a cycle returns its row before the edge that ends that cycle.
  // The read in flight is therefore "pending" only during its own cycle,
  // and the slot check reduces to the occupancy seen at the cycle start.
  assign issue      = (state_q == FETCH) && (cnt_q < 2'd2) &&
                      (issued_q < num_q);
  assign pending    = issue;
  assign last_issue = issue && (issued_q == num_q - 1'b1);

  assign push  = pending;
  assign valid = (cnt_q != 2'd0);
  assign pop   = valid && weights_ready;

  // Next occupancy after this edge's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  assign read_en_MM_fc    = issue;
  assign address_fc       = issue ? (base_q + issued_q) : '0;
  assign enable_MM_out_fc = busy_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign weights_valid    = valid;
  assign weights_out      = valid ? data_q[rd_q] : '0;
  assign row_idx          = valid ? idx_q[rd_q] : '0;

  // Job sequencing: capture the job on start, count issued reads, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            num_q    <= num_reads;
            issued_q <= '0;
            busy_q   <= 1'b1;
            if (num_reads == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue) issued_q <= issued_q + 1'b1;
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (cnt_d == 2'd0 && !pending) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; contents are masked at the outputs while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= dataMainMemo_fc;
      idx_q[wr_q]  <= issued_q;
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: directed jobs plus a randomized
// ready pattern, checked against a row-sequence reference model.
module tb_weight_fetch_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int PE = 32;
  localparam int W  = DW * PE;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_reads = '0;
  logic [AW-1:0] address_fc;
  logic          read_en_MM_fc;
  logic          enable_MM_out_fc;
  logic [W-1:0]  dataMainMemo_fc = '0;
  logic [W-1:0]  weights_out;
  logic          weights_valid;
  logic          weights_ready = 1'b0;
  logic [AW-1:0] row_idx;
  logic          busy;
  logic          done;

  weight_fetch_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .parallel_fc_PE(PE)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_reads(num_reads),
    .address_fc(address_fc), .read_en_MM_fc(read_en_MM_fc),
    .enable_MM_out_fc(enable_MM_out_fc),
    .dataMainMemo_fc(dataMainMemo_fc),
    .weights_out(weights_out), .weights_valid(weights_valid),
    .weights_ready(weights_ready), .row_idx(row_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [NR];

  // Weight memory: samples the address on the falling edge.
  always @(negedge clk)
    if (read_en_MM_fc) dataMainMemo_fc <= mem[address_fc];

  int vecs = 0;
  int errs = 0;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state for the current job.
  int job_base, rd_cnt, pop_cnt, done_cnt, done_cyc, busy_cnt, cyc;
  int re_q[$];
  int v_q[$];
  bit stall;
  logic [W-1:0]  held_w;
  logic [AW-1:0] held_i;

  // Observer: compares reads and delivered rows to the expected sequence.
  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (read_en_MM_fc) begin
        chk("rd_addr", W'(address_fc), W'((job_base + rd_cnt) % NR));
        chk("occ_le2", W'((rd_cnt - pop_cnt) < 2), W'(1));
        re_q.push_back(cyc);
        rd_cnt++;
      end
      if (weights_valid) begin
        if (stall) begin
          chk("stall_w", weights_out, held_w);
          chk("stall_i", W'(row_idx), W'(held_i));
        end
        if (weights_ready) begin
          chk("row_data", weights_out, mem[(job_base + pop_cnt) % NR]);
          chk("row_idx", W'(row_idx), W'(pop_cnt));
          pop_cnt++;
          v_q.push_back(cyc);
          stall = 0;
        end else begin
          stall  = 1;
          held_w = weights_out;
          held_i = row_idx;
        end
      end else begin
        stall = 0;
      end
      chk("en_eq_busy", W'(enable_MM_out_fc), W'(busy));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic job(int b, int n);
    @(posedge clk); #1;
    base_addr = AW'(b);
    num_reads = AW'(n);
    start     = 1'b1;
    job_base  = b;
    rd_cnt = 0; pop_cnt = 0; done_cnt = 0; busy_cnt = 0;
    done_cyc = -1; cyc = -1; stall = 0;
    re_q.delete(); v_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, bit rnd);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (rnd) weights_ready = 1'($urandom_range(0, 1));
    end
    chk("done_seen", W'(done_cnt > 0), W'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", W'(done_cnt), W'(1));
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_addr"}, W'(address_fc), '0);
    chk({tag, "_re"}, W'(read_en_MM_fc), '0);
    chk({tag, "_en"}, W'(enable_MM_out_fc), '0);
    chk({tag, "_w"}, weights_out, '0);
    chk({tag, "_v"}, W'(weights_valid), '0);
    chk({tag, "_idx"}, W'(row_idx), '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_done"}, W'(done), '0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < PE; j++)
        mem[i][j*DW +: DW] = $urandom;

    // Power-up reset.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("por");
    reset = 1'b0;

    // Streaming job, ready held high: exact cycle timing.
    weights_ready = 1'b1;
    job(0, 4);
    wait_done(50, 0);
    chk("s_reads", W'(re_q.size()), W'(4));
    chk("s_pops", W'(v_q.size()), W'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < re_q.size()) chk("s_re_cyc", W'(re_q[k]), W'(k + 1));
      if (k < v_q.size())  chk("s_v_cyc", W'(v_q[k]), W'(k + 2));
    end
    chk("s_done_cyc", W'(done_cyc), W'(6));

    // Back-pressure: only two reads may be outstanding.
    weights_ready = 1'b0;
    job(0, 5);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(200);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_reads", W'(rd_cnt), W'(2));
    chk("bp_valid", W'(weights_valid), W'(1));
    chk("bp_idx", W'(row_idx), W'(0));
    chk("bp_pops", W'(pop_cnt), W'(0));
    weights_ready = 1'b1;
    wait_done(50, 0);
    chk("bp_total", W'(pop_cnt), W'(5));

    // Address wrap at the top of memory.
    job(510, 4);
    wait_done(50, 0);
    chk("wrap_pops", W'(pop_cnt), W'(4));

    // Empty job.
    job(7, 0);
    wait_done(20, 0);
    chk("z_reads", W'(rd_cnt), W'(0));
    chk("z_busy", W'(busy_cnt), W'(1));
    chk("z_done_cyc", W'(done_cyc), W'(1));

    // Reset in mid-job, then a fresh job.
    job(0, 8);
    for (int i = 0; i < 50 && pop_cnt < 2; i++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_outs("mid");
    repeat (3) @(posedge clk);
    #1;
    chk("mid_nodone", W'(done_cnt), W'(0));
    reset = 1'b0;
    job(100, 2);
    wait_done(50, 0);
    chk("post_pops", W'(pop_cnt), W'(2));

    // Random ready toggling over a long job.
    job(int'($urandom_range(0, NR - 1)), 64);
    wait_done(3000, 1);
    chk("rnd_pops", W'(pop_cnt), W'(64));
    chk("rnd_reads", W'(rd_cnt), W'(64));

    weights_ready = 1'b0;
    job(int'($urandom_range(0, NR - 1)), int'($urandom_range(1, 40)));
    wait_done(3000, 1);
    chk("rnd2_pops", W'(pop_cnt), W'(int'(num_reads)));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
